m1to4_demux_stream: RTL and testbench

//  Registered 1-to-4 stream demultiplexer, the inverse of the 4-to-1 mux.
//  One input word stream plus a 2-bit select Sin; each accepted word goes to one of four

---
 rtl/m1to4_demux_stream.sv | 87 ++++++++
 tb/tb_m1to4_demux_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m1to4_demux_stream.sv
// m1to4_demux_stream
//   Registered 1-to-4 stream demultiplexer. Each accepted input word is routed
//   by Sin to one of four channels (A=0, B=1, C=2, D=3). Every channel owns a
//   single-entry output register with valid/ready handshaking, so a stalled
//   channel only back-pressures words aimed at it.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  input handshake (in_ready is combinational on Sin/out_ready)
//   in_data, Sin    input word and its destination channel
//   out_valid[i]    channel i slot FULL
//   out_ready[i]    channel i consumer ready
//   out_data        channel i word  = out_data[i*WIDTH +: WIDTH]
//   out_cnt         channel i count = out_cnt[i*CNT_W +: CNT_W], wraps

// Per-channel slot: one output register, a FULL flag and an accept counter.
module m1to4_demux_lane #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      // A load wins over a drain on the same edge: the slot stays FULL with
      // the new word, giving full throughput without a bubble.
      if (load) begin
        valid <= 1'b1;
        q     <= data;
        cnt   <= cnt + CNT_W'(1);
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

module m1to4_demux_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         Sin,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [4*CNT_W-1:0] out_cnt
);
  localparam int NUM_LANES = 4;

  logic                 acc;
  logic [NUM_LANES-1:0] load;

  // Only the selected slot matters; a slot draining this edge can take a new
  // word, hence the intended combinational out_ready -> in_ready path.
  assign in_ready = ~out_valid[Sin] | out_ready[Sin];
  assign acc      = in_valid & in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign load[i] = acc & (Sin == 2'(i));

    m1to4_demux_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .data  (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (out_data[i*WIDTH +: WIDTH]),
      .cnt   (out_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_m1to4_demux_stream.sv
// Bench for m1to4_demux_stream: directed scenarios plus a random run, all
// checked against a queue-per-channel reference model. A second instance with
// CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_m1to4_demux_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_w;
  logic [7:0]  in_data = '0;
  logic [1:0]  Sin = '0;
  logic [3:0]  out_valid, out_valid_w;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_data, out_data_w;
  logic [63:0] out_cnt;
  logic [15:0] out_cnt_w;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a queue of words not yet consumed.
  logic [7:0] mq [4][$];
  int         mcnt [4];

  always #5 clk = ~clk;

  m1to4_demux_stream #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .Sin(Sin), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  m1to4_demux_stream #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .Sin(Sin), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .out_cnt(out_cnt_w)
  );

  function automatic logic exp_ready();
    return (mq[Sin].size() == 0) || out_ready[Sin];
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  // Advance the model over one clock edge, then move 1 time unit past it.
  task automatic tick();
    logic       a;
    logic [1:0] s;
    logic [7:0] d;
    a = in_valid && exp_ready();
    s = Sin;
    d = in_data;
    for (int i = 0; i < 4; i++)
      if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
    if (a) begin
      mq[s].push_back(d);
      mcnt[s]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mcnt[i] = 0;
    end
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 4'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();
    #1 rst = 1'b0;
  endtask

  // Producer rule: a stalled word must stay presented unchanged.
  logic       hold_chk = 1'b0;
  logic [7:0] hold_d;
  logic [1:0] hold_s;
  always @(posedge clk) begin
    if (rst) hold_chk = 1'b0;
    else begin
      if (hold_chk) begin
        checks++;
        if (!in_valid || in_data !== hold_d || Sin !== hold_s) begin
          errors++;
          $display("FAIL producer_hold: valid=%b data=%h sin=%0d, required valid=1 data=%h sin=%0d",
                   in_valid, in_data, Sin, hold_d, hold_s);
        end
      end
      hold_chk = in_valid && !in_ready;
      hold_d   = in_data;
      hold_s   = Sin;
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; Sin = 2'd1; in_data = 8'h77; out_ready = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
    checks++; if (out_cnt !== 64'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", out_cnt); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (out_valid_w !== 4'h0 || out_cnt_w !== 16'h0) begin errors++; $display("FAIL reset_w: valid %b cnt %h want 0", out_valid_w, out_cnt_w); end
    model_clear();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_release_valid: got %b want 0000", out_valid); end
  endtask

  task automatic test_routing();
    logic [7:0] w;
    apply_reset();
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      w = 8'(8'h11 * (k + 1));
      in_valid = 1'b1; Sin = 2'(k); in_data = w;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready%0d: got %b want 1", k, in_ready); end
      tick();
      checks++; if (out_valid !== 4'(1 << k)) begin errors++; $display("FAIL route_valid%0d: got %b want %b", k, out_valid, 4'(1 << k)); end
      checks++; if (out_data[k*8 +: 8] !== w) begin errors++; $display("FAIL route_data%0d: got %h want %h", k, out_data[k*8 +: 8], w); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL route_drain: got %b want 0000", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_cnt[i*16 +: 16] !== 16'd1) begin errors++; $display("FAIL route_cnt%0d: got %0d want 1", i, out_cnt[i*16 +: 16]); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 4'b1011;
    in_valid = 1'b1; Sin = 2'd2; in_data = 8'hAA;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready: got %b want 1", in_ready); end
    tick();
    Sin = 2'd0; in_data = 8'h5A;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_other_ready: got %b want 1", in_ready); end
    checks++; if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'hAA) begin errors++; $display("FAIL stall_c_held: valid %b data %h want 1 AA", out_valid[2], out_data[23:16]); end
    tick();
    checks++; if (out_valid !== 4'b0101 || out_data[7:0] !== 8'h5A) begin errors++; $display("FAIL stall_a_loaded: valid %b dataA %h want 0101 5A", out_valid, out_data[7:0]); end
    Sin = 2'd2; in_data = 8'hBB;
    for (int r = 0; r < 2; r++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_bb_ready%0d: got %b want 0", r, in_ready); end
      checks++; if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'hAA) begin errors++; $display("FAIL stall_aa_hold%0d: valid %b data %h want 1 AA", r, out_valid[2], out_data[23:16]); end
      tick();
    end
    out_ready = 4'hF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hBB) begin errors++; $display("FAIL stall_bb_out: valid %b data %h want 0100 BB", out_valid, out_data[23:16]); end
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL stall_final_valid: got %b want 0000", out_valid); end
    checks++; if (out_cnt[47:32] !== 16'd2 || out_cnt[15:0] !== 16'd1) begin errors++; $display("FAIL stall_cnt: C %0d A %0d want 2 1", out_cnt[47:32], out_cnt[15:0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev;
    apply_reset();
    out_ready = 4'hF;
    prev = '0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; Sin = 2'd3; in_data = 8'($urandom);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
      if (k > 0) begin
        checks++; if (out_valid[3] !== 1'b1 || out_data[31:24] !== prev) begin errors++; $display("FAIL b2b_beat%0d: valid %b data %h want 1 %h", k, out_valid[3], out_data[31:24], prev); end
      end
      prev = in_data;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid[3] !== 1'b1 || out_data[31:24] !== prev) begin errors++; $display("FAIL b2b_last: valid %b data %h want 1 %h", out_valid[3], out_data[31:24], prev); end
    checks++; if (out_cnt[63:48] !== 16'd16) begin errors++; $display("FAIL b2b_cnt: got %0d want 16", out_cnt[63:48]); end
    tick();
    checks++; if (out_valid[3] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid[3]); end
  endtask

  task automatic test_wrap();
    apply_reset();
    out_ready = 4'hF;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; Sin = 2'd1; in_data = 8'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_cnt_w[7:4] !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d want 1", out_cnt_w[7:4]); end
    checks++; if (out_cnt[31:16] !== 16'd17) begin errors++; $display("FAIL wrap_cnt16: got %0d want 17", out_cnt[31:16]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_valid = 1'b1; Sin = 2'd0; in_data = 8'h3C;
    tick();
    Sin = 2'd2; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0101) begin errors++; $display("FAIL mid_full: got %b want 0101", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 4'h0 || out_valid_w !== 4'h0) begin errors++; $display("FAIL mid_async_clear: got %b/%b want 0000", out_valid, out_valid_w); end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL mid_release: got %b want 0000", out_valid); end
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL mid_no_pulse: got %b want 0000", out_valid); end
    out_ready = 4'hF;
    in_valid = 1'b1; Sin = 2'd0; in_data = 8'h96;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h96) begin errors++; $display("FAIL mid_first_word: valid %b data %h want 0001 96", out_valid, out_data[7:0]); end
    checks++; if (out_cnt[15:0] !== 16'd1 || out_cnt[47:32] !== 16'd0) begin errors++; $display("FAIL mid_cnt: A %0d C %0d want 1 0", out_cnt[15:0], out_cnt[47:32]); end
    tick();
  endtask

  task automatic test_random();
    logic stalled;
    apply_reset();
    stalled = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        Sin      = 2'($urandom);
        in_data  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
      checks++; if (out_valid !== exp_valid() || out_valid_w !== exp_valid()) begin errors++; $display("FAIL rand_valid c%0d: got %b/%b want %b", c, out_valid, out_valid_w, exp_valid()); end
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0) begin
          checks++; if (out_data[i*8 +: 8] !== mq[i][0]) begin errors++; $display("FAIL rand_data c%0d ch%0d: got %h want %h", c, i, out_data[i*8 +: 8], mq[i][0]); end
        end
        checks++; if (out_cnt[i*16 +: 16] !== 16'(mcnt[i]) || out_cnt_w[i*4 +: 4] !== 4'(mcnt[i])) begin errors++; $display("FAIL rand_cnt c%0d ch%0d: got %0d/%0d want %0d", c, i, out_cnt[i*16 +: 16], out_cnt_w[i*4 +: 4], mcnt[i]); end
      end
      stalled = in_valid && !exp_ready();
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
